// File: rtl/tpg_pkg.sv
// Shared constants for the toggle pattern generator: FSM state encoding and
// pattern update rules.
package tpg_pkg;

  localparam logic [1:0] TPG_IDLE  = 2'd0;
  localparam logic [1:0] TPG_DELAY = 2'd1;
  localparam logic [1:0] TPG_RUN   = 2'd2;

  localparam logic [1:0] TPG_INV = 2'd0;
  localparam logic [1:0] TPG_ROL = 2'd1;
  localparam logic [1:0] TPG_ROR = 2'd2;
  localparam logic [1:0] TPG_XOR = 2'd3;

endpackage

// File: rtl/tpg_pattern_next.sv
// Combinational next-pattern rule: invert, rotate left/right by one, or XOR
// with a mask.
module tpg_pattern_next
  import tpg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pat,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pat_nxt
);

  // Select the update rule; the MSB wraps to bit 0 on ROL, bit 0 to the MSB on ROR.
  always_comb begin
    pat_nxt = pat;
    case (mode)
      TPG_INV: pat_nxt = ~pat;
      TPG_ROL: pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
      TPG_ROR: pat_nxt = {pat[0], pat[WIDTH-1:1]};
      TPG_XOR: pat_nxt = pat ^ mask;
      default: pat_nxt = pat;
    endcase
  end

endmodule

// File: rtl/toggle_pattern_gen.sv
// Runtime-configurable toggle pattern generator: programmable first delay,
// update period, update rule and burst length with START/STOP/BUSY/DONE handshake.
module toggle_pattern_gen
  import tpg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int NTOG_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [1:0]        MODE,
  input  logic [CNT_W-1:0]  FIRST_DLY,
  input  logic [CNT_W-1:0]  HALF_PER,
  input  logic [NTOG_W-1:0] NUM_TOG,
  input  logic [WIDTH-1:0]  SEED,
  input  logic [WIDTH-1:0]  MASK,
  output logic [WIDTH-1:0]  OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [NTOG_W-1:0] TOG_CNT
);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        mode_r;
  logic [CNT_W-1:0]  first_dly_r;
  logic [CNT_W-1:0]  half_per_r;
  logic [NTOG_W-1:0] num_tog_r;
  logic [WIDTH-1:0]  mask_r;

  logic [WIDTH-1:0]  pat_nxt_s;
  logic              upd_due_s;
  logic              last_upd_s;
  logic [NTOG_W-1:0] tog_inc_s;

  tpg_pattern_next #(
    .WIDTH(WIDTH)
  ) u_pattern_next (
    .pat    (OUT),
    .mode   (mode_r),
    .mask   (mask_r),
    .pat_nxt(pat_nxt_s)
  );

  // An update is due when the counter reaches the latched delay or period.
  always_comb begin
    upd_due_s = 1'b0;
    case (state_r)
      TPG_DELAY: upd_due_s = (cnt_r == first_dly_r);
      TPG_RUN:   upd_due_s = (cnt_r == half_per_r);
      default:   upd_due_s = 1'b0;
    endcase
  end

  assign tog_inc_s  = TOG_CNT + NTOG_W'(1);
  assign last_upd_s = (num_tog_r != {NTOG_W{1'b0}}) && (tog_inc_s == num_tog_r);

  // Control FSM, delay/period counter, latched config and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= TPG_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mode_r      <= 2'd0;
      first_dly_r <= {CNT_W{1'b0}};
      half_per_r  <= {CNT_W{1'b0}};
      num_tog_r   <= {NTOG_W{1'b0}};
      mask_r      <= {WIDTH{1'b0}};
      OUT         <= {WIDTH{1'b0}};
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TOG_CNT     <= {NTOG_W{1'b0}};
    end else begin
      DONE <= 1'b0;
      case (state_r)
        TPG_IDLE: begin
          if (START) begin
            mode_r      <= MODE;
            first_dly_r <= FIRST_DLY;
            half_per_r  <= HALF_PER;
            num_tog_r   <= NUM_TOG;
            mask_r      <= MASK;
            OUT         <= SEED;
            TOG_CNT     <= {NTOG_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            BUSY        <= 1'b1;
            state_r     <= TPG_DELAY;
          end
        end
        TPG_DELAY, TPG_RUN: begin
          // STOP outranks any update scheduled for the same edge.
          if (STOP) begin
            BUSY    <= 1'b0;
            state_r <= TPG_IDLE;
          end else if (upd_due_s) begin
            OUT     <= pat_nxt_s;
            TOG_CNT <= tog_inc_s;
            cnt_r   <= {CNT_W{1'b0}};
            if (last_upd_s) begin
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
              state_r <= TPG_IDLE;
            end else begin
              state_r <= TPG_RUN;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          BUSY    <= 1'b0;
          state_r <= TPG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/toggle_pattern_gen.md
Name: toggle_pattern_gen

Overview:
- Parametrised, runtime-configurable successor to the fixed 8-bit toggle stimulus generator used by the memory-controller/BISR test paths.
- Drives a WIDTH-bit pattern bus and updates it by a selectable rule (invert, rotate left, rotate right, XOR mask):
  - first update comes after a programmable initial delay;
  - later updates come every programmable period.
- Runs either continuously or as a finite burst of NUM_TOG updates, with a START/STOP/BUSY/DONE handshake toward the controller FSM.

Parameters:
- WIDTH, 8, pattern bus width (>=2).
- CNT_W, 8, width of the delay/period counter and its config inputs.
- NTOG_W, 8, width of the update-count limit and the TOG_CNT status output.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-high reset.
- START  in  1  one-cycle start pulse; honoured only in IDLE.
- STOP  in  1  one-cycle abort pulse; honoured only while BUSY.
- MODE  in  2  update rule: 0 invert, 1 rotate-left-by-1, 2 rotate-right-by-1, 3 OUT^MASK.
- FIRST_DLY  in  CNT_W  initial delay value.
- HALF_PER  in  CNT_W  period minus 1.
- NUM_TOG  in  NTOG_W  number of updates per burst; 0 = continuous.
- SEED  in  WIDTH  value loaded onto OUT at start.
- MASK  in  WIDTH  XOR mask for MODE 3.
- OUT  out  WIDTH  pattern bus (registered).
- BUSY  out  1  high in DELAY or RUN.
- DONE  out  1  one-cycle pulse when a finite burst completes.
- TOG_CNT  out  NTOG_W  updates issued since last START (registered).

Behaviour:
- Reset (async, RST=1): state IDLE; cnt=0; OUT=0; BUSY=0; DONE=0; TOG_CNT=0; latched config=0.
- All outputs are registered; nothing is combinational from inputs to outputs.
- FSM states: IDLE, DELAY, RUN.
- IDLE & START:
  - latch MODE, FIRST_DLY, HALF_PER, NUM_TOG, MASK;
  - OUT<=SEED; TOG_CNT<=0; cnt<=0; go to DELAY.
  - BUSY is high from the next cycle.
- Config inputs are ignored while BUSY, so changing them mid-run has no effect.
- DELAY: cnt increments each cycle.
  - When cnt==FIRST_DLY_l: issue an update, cnt<=0, go to RUN.
  - First update lands on the (FIRST_DLY+1)-th edge after the START edge. FIRST_DLY=0 gives an update on the first edge.
- RUN: cnt increments each cycle.
  - When cnt==HALF_PER_l: issue an update, cnt<=0.
  - Updates repeat every HALF_PER+1 cycles. HALF_PER=0 gives an update every cycle.
- Update: OUT<=f(OUT, MODE_l); TOG_CNT<=TOG_CNT+1.
  - TOG_CNT wraps modulo 2^NTOG_W in continuous mode.
  - Rotate: left moves OUT[WIDTH-1] into bit 0; right moves OUT[0] into bit WIDTH-1.
- Burst end: if NUM_TOG_l!=0 and the update being issued is number NUM_TOG_l:
  - on that same edge: state<=IDLE, BUSY<=0, DONE<=1 for exactly one cycle;
  - OUT holds its final value.
- Continuous (NUM_TOG_l==0): runs until STOP; DONE never asserts.
- STOP while BUSY: next edge goes to IDLE, BUSY<=0, no DONE, OUT and TOG_CNT hold.
  - STOP on the same edge as a scheduled update: STOP wins, no update.
  - STOP on the same edge as the final burst update: STOP wins, no update, no DONE.
- START while BUSY is ignored. START with STOP in IDLE: START is taken, STOP ignored.
- START on the cycle DONE is high (state already IDLE) is accepted.
- RST mid-operation: immediate return to reset values. There is no resume.
- Timing equivalence: FIRST_DLY=4, HALF_PER=3, MODE=0, SEED=0, NUM_TOG=0 gives updates at edges 5, 9, 13, … after START.

Decomposition:
- Shared package `tpg_pkg`:
  - state encoding constants (TPG_IDLE, TPG_DELAY, TPG_RUN);
  - MODE constants (TPG_INV, TPG_ROL, TPG_ROR, TPG_XOR).
- One natural sub-module `tpg_pattern_next`: combinational next-pattern function on (OUT, MODE, MASK), parametrised by WIDTH.
- Counter and FSM stay in the top module.

Test Plan:
- Reset: hold RST high, toggle CLK and inputs → OUT=0, BUSY=0, DONE=0, TOG_CNT=0. Assert RST mid-RUN → all outputs return to 0 asynchronously.
- Legacy timing: WIDTH=8, START with FIRST_DLY=4, HALF_PER=3, MODE=0, SEED=8'h00, NUM_TOG=0 → OUT=8'hFF at edge 5, 8'h00 at edge 9, 8'hFF at edge 13. STOP at edge 15 → OUT stays 8'hFF, BUSY=0.
- Finite burst rotate: SEED=8'h01, MODE=1, FIRST_DLY=0, HALF_PER=0, NUM_TOG=3 → OUT goes 01,02,04,08 on consecutive edges; DONE high for 1 cycle with OUT=8'h08, TOG_CNT=3.
- Wrap and XOR: MODE=2 with SEED=8'h01 → first update gives 8'h80. MODE=3, MASK=8'hA5, SEED=8'h00, NUM_TOG=2 → 8'hA5 then 8'h00, then DONE.
- Handshake corner cases:
  - START during BUSY → ignored; TOG_CNT unaffected.
  - STOP on the final burst edge → no DONE, OUT unchanged.
  - START on the DONE cycle → new burst begins and OUT reloads SEED.
- Config isolation: change FIRST_DLY, HALF_PER and MODE mid-run → update spacing and rule stay at the latched values.
